// File: rtl/alu_seq_mdu.sv
// Execute-stage ALU: registered single-cycle integer ops plus an iterative
// shift-add multiplier / restoring divider behind a valid/ready handshake.
module alu_seq_mdu #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   alu_sel,
    input  logic [4:0]             alu_function,
    input  logic [DATA_WIDTH-1:0]  alu_src1,
    input  logic [DATA_WIDTH-1:0]  alu_src2,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  alu_result,
    output logic [DATA_WIDTH-1:0]  alu_hi,
    output logic                   alu_zero,
    output logic                   alu_ovf,
    output logic                   div_zero,
    output logic                   op_err
);
    localparam int unsigned W = DATA_WIDTH;

    localparam logic [4:0] F_SLL  = 5'b00000, F_SRL  = 5'b00010, F_SRA  = 5'b00011;
    localparam logic [4:0] F_ADD  = 5'b10000, F_ADDU = 5'b10001;
    localparam logic [4:0] F_SUB  = 5'b10010, F_SUBU = 5'b10011;
    localparam logic [4:0] F_AND  = 5'b10100, F_OR   = 5'b10101;
    localparam logic [4:0] F_XOR  = 5'b10110, F_NOR  = 5'b10111;
    localparam logic [4:0] F_SLT  = 5'b11010, F_SLTU = 5'b11011;

    typedef enum logic [1:0] {IDLE, ITER, FIX, OUT} state_t;

    state_t                 state;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic [W-1:0]           hi_q, lo_q, b_q, a_q;
    logic                   md_div_q, neg_res_q, neg_rem_q;
    logic                   zero_p, ovf_p, dz_p, err_p;

    logic [W-1:0]   add_res, sub_res, sc_res, mag1, mag2;
    logic           sc_ovf, sc_legal, md_legal, md_signed;
    logic [W:0]     mul_sum, div_sh, div_diff;
    logic [2*W-1:0] prod_neg;

    // Single-cycle datapath and operand conditioning for mul/div
    always_comb begin
        add_res  = alu_src1 + alu_src2;
        sub_res  = alu_src1 - alu_src2;
        sc_res   = '0;
        sc_ovf   = 1'b0;
        sc_legal = 1'b1;
        case (alu_function)
            F_SLL:  sc_res = alu_src1 << shamt;
            F_SRL:  sc_res = alu_src1 >> shamt;
            F_SRA:  sc_res = W'($signed(alu_src1) >>> shamt);
            F_ADD: begin
                sc_res = add_res;
                sc_ovf = (alu_src1[W-1] == alu_src2[W-1]) && (add_res[W-1] != alu_src1[W-1]);
            end
            F_ADDU: sc_res = add_res;
            F_SUB: begin
                sc_res = sub_res;
                sc_ovf = (alu_src1[W-1] != alu_src2[W-1]) && (sub_res[W-1] != alu_src1[W-1]);
            end
            F_SUBU: sc_res = sub_res;
            F_AND:  sc_res = alu_src1 & alu_src2;
            F_OR:   sc_res = alu_src1 | alu_src2;
            F_XOR:  sc_res = alu_src1 ^ alu_src2;
            F_NOR:  sc_res = ~(alu_src1 | alu_src2);
            F_SLT:  sc_res = W'($signed(alu_src1) < $signed(alu_src2));
            F_SLTU: sc_res = W'(alu_src1 < alu_src2);
            default: sc_legal = 1'b0;
        endcase
        md_legal  = (alu_function[4:2] == 3'b010);
        md_signed = ~alu_function[0];
        mag1 = (md_signed && alu_src1[W-1]) ? -alu_src1 : alu_src1;
        mag2 = (md_signed && alu_src2[W-1]) ? -alu_src2 : alu_src2;
    end

    // One multiply (shift-add) or divide (restoring) step on the magnitudes
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {hi_q, lo_q[W-1]};
        div_diff = div_sh - {1'b0, b_q};
        prod_neg = -{hi_q, lo_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            a_q        <= '0;
            md_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_p     <= 1'b0;
            ovf_p      <= 1'b0;
            dz_p       <= 1'b0;
            err_p      <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            alu_result <= '0;
            alu_hi     <= '0;
            alu_zero   <= 1'b0;
            alu_ovf    <= 1'b0;
            div_zero   <= 1'b0;
            op_err     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // in_ready re-opens the cycle after the out_valid pulse
            if (out_valid) in_ready <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        zero_p   <= (alu_src1 == alu_src2);
                        a_q      <= alu_src1;
                        hi_q     <= '0;
                        ovf_p    <= 1'b0;
                        dz_p     <= 1'b0;
                        err_p    <= 1'b0;
                        if (!alu_sel && sc_legal) begin
                            lo_q  <= sc_res;
                            ovf_p <= sc_ovf;
                            state <= OUT;
                        end else if (alu_sel && md_legal) begin
                            lo_q      <= mag1;
                            b_q       <= mag2;
                            md_div_q  <= alu_function[1];
                            neg_res_q <= md_signed && (alu_src1[W-1] ^ alu_src2[W-1]);
                            neg_rem_q <= md_signed && alu_src1[W-1];
                            dz_p      <= alu_function[1] && (alu_src2 == '0);
                            cnt       <= SHAMT_WIDTH'(W - 1);
                            state     <= ITER;
                        end else begin
                            lo_q  <= '0;
                            err_p <= 1'b1;
                            state <= OUT;
                        end
                    end
                end
                ITER: begin
                    if (md_div_q) begin
                        if (!div_diff[W]) begin
                            hi_q <= div_diff[W-1:0];
                            lo_q <= {lo_q[W-2:0], 1'b1};
                        end else begin
                            hi_q <= div_sh[W-1:0];
                            lo_q <= {lo_q[W-2:0], 1'b0};
                        end
                    end else begin
                        hi_q <= mul_sum[W:1];
                        lo_q <= {mul_sum[0], lo_q[W-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    // Divide by zero bypasses sign correction entirely
                    if (dz_p) begin
                        lo_q <= '1;
                        hi_q <= a_q;
                    end else if (md_div_q) begin
                        if (neg_res_q) lo_q <= -lo_q;
                        if (neg_rem_q) hi_q <= -hi_q;
                    end else if (neg_res_q) begin
                        {hi_q, lo_q} <= prod_neg;
                    end
                    state <= OUT;
                end
                OUT: begin
                    out_valid  <= 1'b1;
                    alu_result <= lo_q;
                    alu_hi     <= hi_q;
                    alu_zero   <= zero_p;
                    alu_ovf    <= ovf_p;
                    div_zero   <= dz_p;
                    op_err     <= err_p;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_mdu.sv
// Directed scoreboard bench for alu_seq_mdu: the driver queues expected
// responses at accept, an independent monitor checks each out_valid pulse.
module tb_alu_seq_mdu;
    localparam int DW = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          alu_sel;
    logic [4:0]    alu_function;
    logic [DW-1:0] alu_src1, alu_src2;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic [DW-1:0] alu_result, alu_hi;
    logic          alu_zero, alu_ovf, div_zero, op_err;

    alu_seq_mdu #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sel(alu_sel), .alu_function(alu_function),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .shamt(shamt),
        .out_valid(out_valid), .alu_result(alu_result), .alu_hi(alu_hi),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .div_zero(div_zero), .op_err(op_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [DW-1:0] res;
        logic [DW-1:0] hi;
        logic [3:0]    flags;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: flags are packed {zero, ovf, div_zero, op_err}
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got 1, expected 0 at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.nm, "_result"}, 64'(alu_result), 64'(mon_e.res));
                    chk({mon_e.nm, "_hi"}, 64'(alu_hi), 64'(mon_e.hi));
                    chk({mon_e.nm, "_flags"}, 64'({alu_zero, alu_ovf, div_zero, op_err}),
                        64'(mon_e.flags));
                    chk({mon_e.nm, "_latency"}, 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
                end
            end else if (sb.size() != 0) begin
                chk({sb[0].nm, "_in_ready_busy"}, 64'(in_ready), 64'(0));
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ready_timeout: got in_ready 0, expected 1");
        end
    endtask

    task automatic issue(input string nm, input logic sel, input logic [4:0] fn,
                         input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                         input logic [SW-1:0] sh, input logic [DW-1:0] eres,
                         input logic [DW-1:0] ehi, input logic [3:0] eflags, input int elat);
        exp_t e;
        wait_ready();
        alu_sel = sel; alu_function = fn; alu_src1 = s1; alu_src2 = s2; shamt = sh;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.nm = nm; e.res = eres; e.hi = ehi; e.flags = eflags; e.lat = elat; e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; in_valid = 1'b0; alu_sel = 1'b0; alu_function = '0;
        alu_src1 = '0; alu_src2 = '0; shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_result", 64'(alu_result), 64'(0));
        chk("reset_hi", 64'(alu_hi), 64'(0));
        chk("reset_flags", 64'({alu_zero, alu_ovf, div_zero, op_err}), 64'(0));

        issue("add_ovf",  0, 5'b10000, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 4'b0100, 2);
        issue("addu",     0, 5'b10001, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 4'b0000, 2);
        issue("sub_zero", 0, 5'b10010, 32'd5, 32'd5, 0, 32'h0, 0, 4'b1000, 2);
        issue("sub_ovf",  0, 5'b10010, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 0, 4'b0100, 2);
        issue("subu",     0, 5'b10011, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 0, 4'b0000, 2);
        issue("slt",      0, 5'b11010, 32'hFFFFFFFF, 32'h1, 0, 32'h1, 0, 4'b0000, 2);
        issue("sltu",     0, 5'b11011, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 0, 4'b0000, 2);
        issue("sra",      0, 5'b00011, 32'h80000000, 32'h0, 4, 32'hF8000000, 0, 4'b0000, 2);
        issue("srl",      0, 5'b00010, 32'h80000000, 32'h0, 31, 32'h1, 0, 4'b0000, 2);
        issue("sll",      0, 5'b00000, 32'h1, 32'h0, 31, 32'h80000000, 0, 4'b0000, 2);
        issue("and",      0, 5'b10100, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0, 4'b0000, 2);
        issue("or",       0, 5'b10101, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 0, 4'b0000, 2);
        issue("xor",      0, 5'b10110, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0, 4'b0000, 2);
        issue("nor",      0, 5'b10111, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h000F000F, 0, 4'b0000, 2);

        issue("mult", 1, 5'b01000, 32'hFFFFFFFD, 32'd7, 0, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b0000, 35);
        // Stray request mid-iteration must be ignored
        repeat (5) @(negedge clk);
        alu_sel = 1'b0; alu_function = 5'b10000; alu_src1 = 32'd1; alu_src2 = 32'd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;

        issue("multu", 1, 5'b01001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1, 32'hFFFFFFFE, 4'b1000, 35);
        issue("div",   1, 5'b01010, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0000, 35);
        issue("div_pn", 1, 5'b01010, 32'd7, 32'hFFFFFFFE, 0, 32'hFFFFFFFD, 32'd1, 4'b0000, 35);
        issue("div_min", 1, 5'b01010, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 32'h0, 4'b0000, 35);
        issue("divu_z", 1, 5'b01011, 32'd100, 32'd0, 0, 32'hFFFFFFFF, 32'd100, 4'b0010, 35);
        issue("div_z_neg", 1, 5'b01010, 32'hFFFFFFF9, 32'd0, 0, 32'hFFFFFFFF, 32'hFFFFFFF9, 4'b0010, 35);
        issue("illegal_md", 1, 5'b10000, 32'd3, 32'd4, 0, 32'h0, 32'h0, 4'b0001, 2);
        issue("illegal_sc", 0, 5'b01000, 32'd3, 32'd3, 0, 32'h0, 32'h0, 4'b1001, 2);

        // Abort a multiply with reset mid-iteration
        issue("mult_abort", 1, 5'b01001, 32'd9, 32'd9, 0, 32'd81, 32'd0, 4'b1000, 35);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_result_cleared", 64'(alu_result), 64'(0));
        chk("abort_flags_cleared", 64'({alu_zero, alu_ovf, div_zero, op_err}), 64'(0));
        repeat (40) @(negedge clk);

        issue("divu", 1, 5'b01011, 32'd100, 32'd7, 0, 32'd14, 32'd2, 4'b0000, 35);
        issue("add_after", 0, 5'b10000, 32'd10, 32'd20, 0, 32'd30, 0, 4'b0000, 2);

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
